// File: rtl/quadrilatero_row_reader.sv
// ============================================================================
// quadrilatero_row_reader : streams every row of one matrix register out of
// the RF read port, with a queued command front end and a finished/ack report.
// Revision: 1.0
// ============================================================================
`default_nettype none

package xif_pkg;
    localparam int unsigned X_ID_WIDTH = 4;
endpackage

module quadrilatero_row_reader #(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned RLEN       = 128,
    parameter int unsigned N_REGS     = 8,
    parameter int unsigned N_ROWS     = 4,
    parameter int unsigned OBUF_DEPTH = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    output logic [$clog2(N_REGS)-1:0]                 raddr_o,
    output logic [$clog2(N_ROWS)-1:0]                 rrowaddr_o,
    output logic                                      re_o,
    input  logic                                      rready_i,
    input  logic [RLEN-1:0]                           rdata_i,
    input  logic [$clog2(N_REGS)-1:0]                 operand_reg_i,
    input  logic                                      start_i,
    input  logic [xif_pkg::X_ID_WIDTH-1:0]            instr_id_i,
    output logic                                      busy_o,
    output logic [xif_pkg::X_ID_WIDTH-1:0]            id_o,
    output logic [RLEN-1:0]                           data_o,
    output logic [$clog2(N_ROWS)-1:0]                 data_rowaddr_o,
    output logic                                      data_last_o,
    output logic                                      data_valid_o,
    input  logic                                      data_ready_i,
    output logic                                      finished_o,
    input  logic                                      finished_ack_i,
    output logic [xif_pkg::X_ID_WIDTH-1:0]            finished_instr_id_o
);

    localparam int unsigned REG_W  = $clog2(N_REGS);
    localparam int unsigned ROW_W  = $clog2(N_ROWS);
    localparam int unsigned ID_W   = xif_pkg::X_ID_WIDTH;
    localparam int unsigned CMD_W  = REG_W + ID_W;
    localparam int unsigned META_W = ROW_W + 1 + ID_W;
    localparam int unsigned CPTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CCNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OPTR_W = $clog2(OBUF_DEPTH);
    localparam int unsigned OCNT_W = $clog2(OBUF_DEPTH + 1);

    localparam logic [CCNT_W-1:0] CMD_FULL   = CCNT_W'(DEPTH);
    localparam logic [CCNT_W-1:0] CMD_ALMOST = CCNT_W'(DEPTH - 1);
    localparam logic [CPTR_W-1:0] CPTR_LAST  = CPTR_W'(DEPTH - 1);
    localparam logic [OPTR_W-1:0] OPTR_LAST  = OPTR_W'(OBUF_DEPTH - 1);
    localparam logic [OCNT_W:0]   OBUF_LIM   = (OCNT_W + 1)'(OBUF_DEPTH);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(N_ROWS - 1);

    if (N_ROWS < 2) begin : g_bad_n_rows
        $error("quadrilatero_row_reader: N_ROWS must be >= 2");
    end
    if (OBUF_DEPTH < 2) begin : g_bad_obuf_depth
        $error("quadrilatero_row_reader: OBUF_DEPTH must be >= 2");
    end

    // ------------------------------------------------------------------
    // Command FIFO (fall-through: an empty FIFO presents the incoming command)
    // ------------------------------------------------------------------
    logic [CMD_W-1:0]  cmd_mem [0:(1 << CPTR_W)-1];
    logic [CPTR_W-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [CCNT_W-1:0] cmd_cnt;
    logic              cmd_full, cmd_stored, push_req, cmd_valid;
    logic              cmd_pop, cmd_write, cmd_read;
    logic [CMD_W-1:0]  cmd_head;

    assign cmd_full   = (cmd_cnt == CMD_FULL);
    assign cmd_stored = (cmd_cnt != '0);
    assign push_req   = start_i & ~cmd_full;
    assign cmd_valid  = cmd_stored | push_req;
    assign cmd_head   = cmd_stored ? cmd_mem[cmd_rd_ptr] : {operand_reg_i, instr_id_i};
    assign cmd_write  = push_req & ~(cmd_pop & ~cmd_stored);
    assign cmd_read   = cmd_pop & cmd_stored;
    assign busy_o     = cmd_full | (cmd_cnt == CMD_ALMOST);

    always_ff @(posedge clk_i) begin
        if (cmd_write) begin
            cmd_mem[cmd_wr_ptr] <= {operand_reg_i, instr_id_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_cnt    <= '0;
        end else begin
            if (cmd_write) begin
                cmd_wr_ptr <= (cmd_wr_ptr == CPTR_LAST) ? '0 : cmd_wr_ptr + CPTR_W'(1);
            end
            if (cmd_read) begin
                cmd_rd_ptr <= (cmd_rd_ptr == CPTR_LAST) ? '0 : cmd_rd_ptr + CPTR_W'(1);
            end
            case ({cmd_write, cmd_read})
                2'b10:   cmd_cnt <= cmd_cnt + CCNT_W'(1);
                2'b01:   cmd_cnt <= cmd_cnt - CCNT_W'(1);
                default: cmd_cnt <= cmd_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t            state, state_next;
    logic              load_cmd, credit_ok, accept, obuf_pop;
    logic [REG_W-1:0]  raddr_q;
    logic [ROW_W-1:0]  row_q;
    logic [ID_W-1:0]   id_q;
    logic [OCNT_W-1:0] occ_q;
    logic              inflight_q;
    logic [OCNT_W:0]   credit_sum;

    // Rows already buffered or landing, less the one leaving, must leave room.
    assign credit_sum = {1'b0, occ_q} + {{OCNT_W{1'b0}}, inflight_q}
                      - {{OCNT_W{1'b0}}, obuf_pop};
    assign credit_ok  = (credit_sum < OBUF_LIM);
    assign accept     = re_o & rready_i;

    always_comb begin
        state_next = state;
        cmd_pop    = 1'b0;
        load_cmd   = 1'b0;
        re_o       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_pop    = 1'b1;
                    load_cmd   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                re_o = credit_ok;
                if (re_o && rready_i && (row_q == ROW_LAST)) begin
                    if (cmd_valid) begin
                        cmd_pop  = 1'b1;
                        load_cmd = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            raddr_q <= '0;
            row_q   <= '0;
            id_q    <= '0;
        end else begin
            state <= state_next;
            if (load_cmd) begin
                raddr_q <= cmd_head[CMD_W-1 -: REG_W];
                id_q    <= cmd_head[ID_W-1:0];
                row_q   <= '0;
            end else if (accept) begin
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    assign raddr_o    = raddr_q;
    assign rrowaddr_o = row_q;
    assign id_o       = id_q;

    // ------------------------------------------------------------------
    // Return path and output buffer
    // ------------------------------------------------------------------
    logic [ROW_W-1:0]  inflight_row_q;
    logic              inflight_last_q;
    logic [ID_W-1:0]   inflight_id_q;
    logic [RLEN-1:0]   obuf_data [0:OBUF_DEPTH-1];
    logic [META_W-1:0] obuf_meta [0:OBUF_DEPTH-1];
    logic [OPTR_W-1:0] obuf_wr_ptr, obuf_rd_ptr;
    logic [ROW_W-1:0]  head_row;
    logic              head_last, hold;
    logic [ID_W-1:0]   head_id;
    logic              finished_q;
    logic [ID_W-1:0]   finished_id_q;

    assign {head_row, head_last, head_id} = obuf_meta[obuf_rd_ptr];

    // A second completion waits for the previous one to be acknowledged.
    assign hold         = head_last & finished_q & ~finished_ack_i;
    assign data_valid_o = (occ_q != '0) & ~hold;
    assign obuf_pop     = data_valid_o & data_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q      <= 1'b0;
            inflight_row_q  <= '0;
            inflight_last_q <= 1'b0;
            inflight_id_q   <= '0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                inflight_row_q  <= row_q;
                inflight_last_q <= (row_q == ROW_LAST);
                inflight_id_q   <= id_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
                obuf_data[i] <= '0;
                obuf_meta[i] <= '0;
            end
            obuf_wr_ptr <= '0;
            obuf_rd_ptr <= '0;
            occ_q       <= '0;
        end else begin
            if (inflight_q) begin
                obuf_data[obuf_wr_ptr] <= rdata_i;
                obuf_meta[obuf_wr_ptr] <= {inflight_row_q, inflight_last_q, inflight_id_q};
                obuf_wr_ptr <= (obuf_wr_ptr == OPTR_LAST) ? '0 : obuf_wr_ptr + OPTR_W'(1);
            end
            if (obuf_pop) begin
                obuf_rd_ptr <= (obuf_rd_ptr == OPTR_LAST) ? '0 : obuf_rd_ptr + OPTR_W'(1);
            end
            case ({inflight_q, obuf_pop})
                2'b10:   occ_q <= occ_q + OCNT_W'(1);
                2'b01:   occ_q <= occ_q - OCNT_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign data_o         = obuf_data[obuf_rd_ptr];
    assign data_rowaddr_o = head_row;
    assign data_last_o    = head_last;

    // A new completion takes priority over an ack arriving in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            finished_q    <= 1'b0;
            finished_id_q <= '0;
        end else if (obuf_pop && head_last) begin
            finished_q    <= 1'b1;
            finished_id_q <= head_id;
        end else if (finished_ack_i) begin
            finished_q    <= 1'b0;
            finished_id_q <= '0;
        end
    end

    assign finished_o          = finished_q;
    assign finished_instr_id_o = finished_id_q;

endmodule

`default_nettype wire

// File: tb/tb_quadrilatero_row_reader.sv
// ============================================================================
// tb_quadrilatero_row_reader : directed scoreboard bench for the row reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_quadrilatero_row_reader;

    localparam int unsigned ID_W = xif_pkg::X_ID_WIDTH;

    logic             clk_i;
    logic             rst_ni;
    logic [2:0]       raddr_o;
    logic [1:0]       rrowaddr_o;
    logic             re_o;
    logic             rready_i;
    logic [127:0]     rdata_i;
    logic [2:0]       operand_reg_i;
    logic             start_i;
    logic [ID_W-1:0]  instr_id_i;
    logic             busy_o;
    logic [ID_W-1:0]  id_o;
    logic [127:0]     data_o;
    logic [1:0]       data_rowaddr_o;
    logic             data_last_o;
    logic             data_valid_o;
    logic             data_ready_i;
    logic             finished_o;
    logic             finished_ack_i;
    logic [ID_W-1:0]  finished_instr_id_o;

    quadrilatero_row_reader #(
        .DEPTH(2), .RLEN(128), .N_REGS(8), .N_ROWS(4), .OBUF_DEPTH(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .raddr_o(raddr_o), .rrowaddr_o(rrowaddr_o), .re_o(re_o),
        .rready_i(rready_i), .rdata_i(rdata_i),
        .operand_reg_i(operand_reg_i), .start_i(start_i), .instr_id_i(instr_id_i),
        .busy_o(busy_o), .id_o(id_o),
        .data_o(data_o), .data_rowaddr_o(data_rowaddr_o), .data_last_o(data_last_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .finished_o(finished_o), .finished_ack_i(finished_ack_i),
        .finished_instr_id_o(finished_instr_id_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]   row;
        logic         last;
        logic [127:0] data;
    } beat_t;

    beat_t           exp_q[$];
    logic [ID_W-1:0] fin_q[$];
    int              vectors = 0;
    int              miscompares = 0;
    int              accepts = 0;
    int              beats = 0;
    logic            acc_now = 1'b0;
    logic [2:0]      acc_reg = '0;
    logic [1:0]      acc_row = '0;

    function automatic logic [127:0] pat(input logic [2:0] r, input logic [1:0] row);
        logic [31:0] w;
        w = {24'hA5C3E1, 3'b000, r, row};
        return {w, ~w, w ^ 32'h0F0F_0F0F, w[15:0], w[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] r, input logic [ID_W-1:0] id);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.row  = 2'(k);
            b.last = (k == 3);
            b.data = pat(r, 2'(k));
            exp_q.push_back(b);
        end
        fin_q.push_back(id);
    endtask

    task automatic drive_start(input logic [2:0] r, input logic [ID_W-1:0] id, input bit expect_taken);
        start_i       = 1'b1;
        operand_reg_i = r;
        instr_id_i    = id;
        if (expect_taken) push_cmd(r, id);
    endtask

    // Mid-cycle sample: RF acceptance, stream beats and completion acks.
    task automatic settle();
        beat_t e;
        #1;
        acc_now = re_o & rready_i;
        if (acc_now) begin
            acc_reg = raddr_o;
            acc_row = rrowaddr_o;
            accepts++;
        end
        if (data_valid_o & data_ready_i) begin
            beats++;
            if (exp_q.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
            else begin
                e = exp_q.pop_front();
                chk("beat", {data_rowaddr_o, data_last_o, data_o}, e);
            end
        end
        if (finished_ack_i & finished_o) begin
            if (fin_q.size() == 0) chk("unexpected_finish", 1'b1, 1'b0);
            else chk("finish_id", finished_instr_id_o, fin_q.pop_front());
        end
    endtask

    // Advance to the next cycle; RF returns data one cycle after acceptance.
    task automatic adv();
        @(negedge clk_i);
        rdata_i = acc_now ? pat(acc_reg, acc_row) : '0;
        acc_now = 1'b0;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || fin_q.size() != 0); i++) tick();
        chk("drain_done", exp_q.size() + fin_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] prev_addr;
        logic       prev_stall;
        int         b0;

        rst_ni = 1'b0; start_i = 1'b0; rready_i = 1'b1; data_ready_i = 1'b1;
        finished_ack_i = 1'b0; operand_reg_i = '0; instr_id_i = '0; rdata_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("reset_outputs",
            {re_o, data_valid_o, finished_o, busy_o, raddr_o, rrowaddr_o, id_o,
             data_rowaddr_o, data_last_o, finished_instr_id_o}, '0);
        chk("reset_data", data_o, '0);
        rst_ni = 1'b1;
        adv();

        // Single command: exact cycle timing.
        for (int c = 0; c < 10; c++) begin
            if (c == 0) drive_start(3'd5, 4'd3, 1'b1);
            if (c == 9) finished_ack_i = 1'b1;
            settle();
            chk("t1_re", re_o, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) begin
                chk("t1_rrow", rrowaddr_o, c - 1);
                chk("t1_raddr", raddr_o, 5);
                chk("t1_id", id_o, 3);
            end
            chk("t1_valid", data_valid_o, (c >= 3 && c <= 6));
            chk("t1_finished", finished_o, (c >= 7));
            adv();
            start_i = 1'b0;
        end
        drain();

        // Two commands back-to-back.
        for (int c = 0; c < 12; c++) begin
            if (c == 0) drive_start(3'd1, 4'd4, 1'b1);
            if (c == 1) drive_start(3'd2, 4'd5, 1'b1);
            settle();
            chk("t2_re", re_o, (c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) begin
                chk("t2_raddr", raddr_o, (c <= 4) ? 1 : 2);
                chk("t2_rrow", rrowaddr_o, (c - 1) % 4);
            end
            adv();
            start_i = 1'b0;
        end
        drain();

        // Consumer stall for 10 cycles mid-stream.
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive_start(3'd3, 4'd6, 1'b1);
            tick();
            start_i = 1'b0;
        end
        data_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("t3_buffered", ((accepts - beats) <= 2), 1'b1);
            chk("t3_re_stalled", re_o, 1'b0);
            adv();
        end
        data_ready_i = 1'b1;
        drain();

        // RF backpressure: addresses held while not accepted.
        prev_stall = 1'b0;
        prev_addr  = '0;
        for (int c = 0; c < 24; c++) begin
            if (c == 0) drive_start(3'd4, 4'd7, 1'b1);
            rready_i = c[0];
            settle();
            if (prev_stall && re_o) chk("t4_addr_stable", {raddr_o, rrowaddr_o}, prev_addr);
            prev_stall = re_o & ~rready_i;
            prev_addr  = {raddr_o, rrowaddr_o};
            adv();
            start_i = 1'b0;
        end
        rready_i = 1'b1;
        drain();

        // Completion hold, then finish and ack in the same cycle.
        finished_ack_i = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c == 0) drive_start(3'd6, 4'd8, 1'b1);
            if (c == 1) drive_start(3'd7, 4'd9, 1'b1);
            tick();
            start_i = 1'b0;
        end
        settle();
        chk("t5_held_valid", data_valid_o, 1'b0);
        chk("t5_held_last", data_last_o, 1'b1);
        chk("t5_fin", finished_o, 1'b1);
        chk("t5_fin_id", finished_instr_id_o, 8);
        adv();
        finished_ack_i = 1'b1;
        settle();
        chk("t5_release_valid", data_valid_o, 1'b1);
        adv();
        finished_ack_i = 1'b0;
        settle();
        chk("t5_fin_kept", finished_o, 1'b1);
        chk("t5_fin_new_id", finished_instr_id_o, 9);
        adv();
        finished_ack_i = 1'b1;
        drain();

        // Busy flag and drop of a start while full.
        b0 = beats;
        drive_start(3'd0, 4'd10, 1'b1);
        settle(); chk("t6_busy0", busy_o, 1'b0); adv();
        drive_start(3'd1, 4'd11, 1'b1);
        settle(); chk("t6_busy1", busy_o, 1'b0); adv();
        drive_start(3'd2, 4'd12, 1'b1);
        settle(); chk("t6_busy2", busy_o, 1'b1); adv();
        drive_start(3'd3, 4'd13, 1'b0);
        settle(); chk("t6_busy_full", busy_o, 1'b1); adv();
        start_i = 1'b0;
        drain();
        repeat (12) tick();
        chk("t6_beat_total", beats - b0, 12);

        // Reset mid-stream drops everything.
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive_start(3'd5, 4'd14, 1'b1);
            tick();
            start_i = 1'b0;
        end
        rst_ni = 1'b0;
        settle();
        chk("rst_mid_outputs",
            {re_o, data_valid_o, finished_o, busy_o, raddr_o, rrowaddr_o, id_o,
             data_rowaddr_o, data_last_o, finished_instr_id_o}, '0);
        chk("rst_mid_data", data_o, '0);
        exp_q.delete();
        fin_q.delete();
        adv();
        rst_ni = 1'b1;
        repeat (12) tick();
        settle();
        chk("rst_no_finish", finished_o, 1'b0);
        chk("rst_idle_valid", data_valid_o, 1'b0);
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
